// File: rtl/mem_line_refill_ctrl_pkg.sv
// Shared constants, FSM state encodings and the word-address helper for the
// cache-line refill controller.
package mem_line_refill_ctrl_pkg;

  localparam int LINE_BITS = 128;
  localparam int WORD_BITS = 32;
  localparam logic [3:0] WEA_ALL = 4'hF;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WB    = 2'd1;
  localparam logic [1:0] ST_RD    = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  // mainMem word address of beat 'beat' within the line whose byte address
  // bits [31:4] are 'line_addr'.
  function automatic logic [31:0] word_addr(input logic [27:0] line_addr,
                                            input logic [1:0]  beat);
    return {2'b00, line_addr, beat};
  endfunction

endpackage

// File: rtl/mem_line_refill_ctrl_rd_tracker.sv
// Tracks outstanding mainMem reads: a MEM_RD_LAT-deep valid shift register
// whose tail marks the cycle douta carries read data, plus a 2-bit counter
// naming which line word that data belongs to.
module mem_rd_return_tracker #(
  parameter int MEM_RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  output logic       capture,
  output logic [1:0] ret_idx
);

  logic [MEM_RD_LAT-1:0] vld_q;
  logic [MEM_RD_LAT-1:0] vld_d;
  logic [1:0]            ret_q;
  logic [1:0]            ret_d;

  generate
    for (genvar gi = 0; gi < MEM_RD_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign vld_d[gi] = push;
      end else begin : g_tail
        assign vld_d[gi] = vld_q[gi-1];
      end
    end
  endgenerate

  assign capture = vld_q[MEM_RD_LAT-1];
  assign ret_idx = ret_q;

  // Advance the return word index on every captured word
  always_comb begin
    ret_d = ret_q;
    if (capture) begin
      ret_d = ret_q + 2'd1;
    end
  end

  // Valid pipeline and return counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      ret_q <= 2'd0;
    end else begin
      vld_q <= vld_d;
      ret_q <= ret_d;
    end
  end

endmodule

// File: rtl/mem_line_refill_ctrl.sv
// Data-cache miss engine on the mainMem single-port interface: optional
// 4-beat write-back of a dirty victim, then a 4-beat pipelined line read,
// returning the assembled 128-bit line with a one-cycle fill_valid pulse.
// All mainMem signals are registered; a beat is "issued" on the edge that
// loads it into the mem_* output flops.
module mem_line_refill_ctrl
  import mem_line_refill_ctrl_pkg::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clka,
  input  logic                 rsta_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  input  logic                 req_wb,
  input  logic [31:0]          wb_addr,
  input  logic [LINE_BITS-1:0] wb_line,
  output logic                 fill_valid,
  output logic [31:0]          fill_addr,
  output logic [LINE_BITS-1:0] fill_line,
  output logic                 mem_ena,
  output logic [3:0]           mem_wea,
  output logic [31:0]          mem_addra,
  output logic [WORD_BITS-1:0] mem_dina,
  input  logic [WORD_BITS-1:0] mem_douta
);

  localparam logic [2:0] LAST_BEAT = 3'(LINE_WORDS - 1);

  logic [1:0]           state_q, state_d;
  logic [2:0]           beat_q, beat_d;
  logic [27:0]          req_line_q, req_line_d;
  logic [27:0]          wb_line_addr_q, wb_line_addr_d;
  logic [LINE_BITS-1:0] wb_data_q, wb_data_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic                 fill_valid_q, fill_valid_d;
  logic [31:0]          fill_addr_q, fill_addr_d;
  logic [LINE_BITS-1:0] fill_line_q, fill_line_d;
  logic                 mem_ena_q, mem_ena_d;
  logic [3:0]           mem_wea_q, mem_wea_d;
  logic [31:0]          mem_addra_q, mem_addra_d;
  logic [WORD_BITS-1:0] mem_dina_q, mem_dina_d;

  logic                 capture;
  logic [1:0]           ret_idx;
  logic                 unused_addr_bits;

  // Byte-offset bits of the line addresses carry no information
  assign unused_addr_bits = ^{req_addr[3:0], wb_addr[3:0]};

  // A read beat reaches mainMem in the cycle mem_ena is high with wea clear
  mem_rd_return_tracker #(
    .MEM_RD_LAT(MEM_RD_LAT)
  ) u_rd_tracker (
    .clk    (clka),
    .rst_n  (rsta_n),
    .push   (mem_ena_q && (mem_wea_q == 4'h0)),
    .capture(capture),
    .ret_idx(ret_idx)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign fill_valid = fill_valid_q;
  assign fill_addr  = fill_addr_q;
  assign fill_line  = fill_line_q;
  assign mem_ena    = mem_ena_q;
  assign mem_wea    = mem_wea_q;
  assign mem_addra  = mem_addra_q;
  assign mem_dina   = mem_dina_q;

  // Next-state, next-beat and registered mainMem drive; read returns are
  // assembled into line_q and published on the word-3 capture.
  always_comb begin
    state_d        = state_q;
    beat_d         = beat_q;
    req_line_d     = req_line_q;
    wb_line_addr_d = wb_line_addr_q;
    wb_data_d      = wb_data_q;
    line_d         = line_q;
    fill_valid_d   = 1'b0;
    fill_addr_d    = fill_addr_q;
    fill_line_d    = fill_line_q;
    mem_ena_d      = 1'b0;
    mem_wea_d      = 4'h0;
    mem_addra_d    = mem_addra_q;
    mem_dina_d     = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_line_d     = req_addr[31:4];
          wb_line_addr_d = wb_addr[31:4];
          wb_data_d      = wb_line;
          beat_d         = 3'd0;
          state_d        = req_wb ? ST_WB : ST_RD;
        end
      end
      ST_WB: begin
        mem_ena_d   = 1'b1;
        mem_wea_d   = WEA_ALL;
        mem_addra_d = word_addr(wb_line_addr_q, beat_q[1:0]);
        mem_dina_d  = wb_data_q[{beat_q[1:0], 5'd0} +: WORD_BITS];
        if (beat_q == LAST_BEAT) begin
          // Read beat 0 follows write beat 3 on the very next edge
          state_d = ST_RD;
          beat_d  = 3'd0;
        end else begin
          beat_d = beat_q + 3'd1;
        end
      end
      ST_RD: begin
        // beat_q runs one past the last beat so DRAIN starts only once
        // the final read beat has left the output flops
        if (beat_q <= LAST_BEAT) begin
          mem_ena_d   = 1'b1;
          mem_addra_d = word_addr(req_line_q, beat_q[1:0]);
          beat_d      = beat_q + 3'd1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
      end
    endcase

    if (capture) begin
      line_d[{ret_idx, 5'd0} +: WORD_BITS] = mem_douta;
      if (ret_idx == 2'd3) begin
        fill_valid_d = 1'b1;
        fill_addr_d  = {req_line_q, 4'h0};
        fill_line_d  = line_d;
        state_d      = ST_IDLE;
        beat_d       = 3'd0;
      end
    end
  end

  // Controller state and output registers
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q        <= ST_IDLE;
      beat_q         <= 3'd0;
      req_line_q     <= '0;
      wb_line_addr_q <= '0;
      wb_data_q      <= '0;
      line_q         <= '0;
      fill_valid_q   <= 1'b0;
      fill_addr_q    <= '0;
      fill_line_q    <= '0;
      mem_ena_q      <= 1'b0;
      mem_wea_q      <= 4'h0;
      mem_addra_q    <= '0;
      mem_dina_q     <= '0;
    end else begin
      state_q        <= state_d;
      beat_q         <= beat_d;
      req_line_q     <= req_line_d;
      wb_line_addr_q <= wb_line_addr_d;
      wb_data_q      <= wb_data_d;
      line_q         <= line_d;
      fill_valid_q   <= fill_valid_d;
      fill_addr_q    <= fill_addr_d;
      fill_line_q    <= fill_line_d;
      mem_ena_q      <= mem_ena_d;
      mem_wea_q      <= mem_wea_d;
      mem_addra_q    <= mem_addra_d;
      mem_dina_q     <= mem_dina_d;
    end
  end

endmodule

// File: tb/tb_mem_line_refill_ctrl.sv
// Directed bench for mem_line_refill_ctrl: four instances with
// MEM_RD_LAT=1..4 share one stimulus; each has a mainMem model returning
// 32'hA0 + word address after its read latency.
module tb_mem_line_refill_ctrl;

  typedef struct {
    logic [31:0]  req_addr;
    logic         req_wb;
    logic [31:0]  wb_addr;
    logic [127:0] wb_line;
    logic [127:0] exp_line;
    logic [31:0]  exp_faddr;
    int           exp_lat;   // accept edge to fill_valid cycle at MEM_RD_LAT=1
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] dina;
    logic [3:0]  wea;
  } beat_t;

  logic         clk = 1'b0;
  logic         rsta_n = 1'b0;
  logic         req_valid = 1'b0;
  logic [31:0]  req_addr = '0;
  logic         req_wb = 1'b0;
  logic [31:0]  wb_addr = '0;
  logic [127:0] wb_line = '0;

  logic         req_ready_a  [1:4];
  logic         fill_valid_a [1:4];
  logic [31:0]  fill_addr_a  [1:4];
  logic [127:0] fill_line_a  [1:4];
  logic         ena_a        [1:4];
  logic [3:0]   wea_a        [1:4];
  logic [31:0]  addra_a      [1:4];
  logic [31:0]  dina_a       [1:4];
  logic [31:0]  douta_a      [1:4];

  int           fcnt  [1:4];
  int           fcyc  [1:4];
  logic [127:0] fline [1:4];
  logic [31:0]  faddr [1:4];

  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  beat_t blog[$];
  vec_t  vecs [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar gi = 1; gi <= 4; gi++) begin : g_dut
      logic [31:0] pipe [0:gi-1];

      mem_line_refill_ctrl #(.MEM_RD_LAT(gi), .LINE_WORDS(4)) u_dut (
        .clka      (clk),
        .rsta_n    (rsta_n),
        .req_valid (req_valid),
        .req_ready (req_ready_a[gi]),
        .req_addr  (req_addr),
        .req_wb    (req_wb),
        .wb_addr   (wb_addr),
        .wb_line   (wb_line),
        .fill_valid(fill_valid_a[gi]),
        .fill_addr (fill_addr_a[gi]),
        .fill_line (fill_line_a[gi]),
        .mem_ena   (ena_a[gi]),
        .mem_wea   (wea_a[gi]),
        .mem_addra (addra_a[gi]),
        .mem_dina  (dina_a[gi]),
        .mem_douta (douta_a[gi])
      );

      // mainMem model: read data appears gi cycles after the sampling edge
      always @(posedge clk) begin
        pipe[0] <= (ena_a[gi] && wea_a[gi] == 4'h0) ? 32'hA0 + addra_a[gi] : 32'hDEADBEEF;
        for (int i = 1; i < gi; i++) pipe[i] <= pipe[i-1];
      end
      assign douta_a[gi] = pipe[gi-1];

      always @(negedge clk) begin
        if (fill_valid_a[gi]) begin
          fcnt[gi]  = fcnt[gi] + 1;
          fcyc[gi]  = cyc;
          fline[gi] = fill_line_a[gi];
          faddr[gi] = fill_addr_a[gi];
        end
      end
    end
  endgenerate

  // Beat log of the MEM_RD_LAT=1 instance
  always @(negedge clk) begin
    if (ena_a[1]) blog.push_back('{cyc, addra_a[1], dina_a[1], wea_a[1]});
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_fills();
    for (int g = 1; g <= 4; g++) fcnt[g] = 0;
  endtask

  task automatic wait_all_ready();
    int n = 0;
    while (!(req_ready_a[1] && req_ready_a[2] && req_ready_a[3] && req_ready_a[4]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int acc;
    int nb;
    wait_all_ready();
    @(negedge clk);
    clear_fills();
    blog.delete();
    req_addr = v.req_addr; req_wb = v.req_wb; wb_addr = v.wb_addr; wb_line = v.wb_line;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    req_valid = 1'b0;
    chk($sformatf("v%0d_accepted", id), req_ready_a[1], 1'b0);
    repeat (25) @(negedge clk);
    for (int g = 1; g <= 4; g++) begin
      chk($sformatf("v%0d_lat%0d_fill_count", id, g), fcnt[g], 1);
      chk($sformatf("v%0d_lat%0d_fill_cycle", id, g), fcyc[g] - acc, v.exp_lat + g - 1);
      chk($sformatf("v%0d_lat%0d_fill_line", id, g), fline[g], v.exp_line);
    end
    chk($sformatf("v%0d_fill_addr", id), faddr[1], v.exp_faddr);
    nb = v.req_wb ? 8 : 4;
    chk($sformatf("v%0d_beat_count", id), blog.size(), nb);
    for (int k = 0; k < nb && k < blog.size(); k++) begin
      logic        is_wr;
      logic [1:0]  b;
      logic [31:0] la;
      is_wr = v.req_wb && k < 4;
      b  = 2'(k % 4);
      la = is_wr ? v.wb_addr : v.req_addr;
      chk($sformatf("v%0d_beat%0d_cycle", id, k), blog[k].cyc - acc, k + 1);
      chk($sformatf("v%0d_beat%0d_addr", id, k), blog[k].addr, {2'b00, la[31:4], b});
      chk($sformatf("v%0d_beat%0d_wea", id, k), blog[k].wea, is_wr ? 4'hF : 4'h0);
      chk($sformatf("v%0d_beat%0d_dina", id, k), blog[k].dina, is_wr ? v.wb_line[32*b +: 32] : 32'h0);
    end
    $display("[TB] vec %0d addr=%h wb=%0d fill=%h", id, v.req_addr, v.req_wb, fline[1]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready_a[1], 1'b1);
    chk({tag, "_fill_valid"}, fill_valid_a[1], 1'b0);
    chk({tag, "_fill_addr"}, fill_addr_a[1], 32'h0);
    chk({tag, "_fill_line"}, fill_line_a[1], 128'h0);
    chk({tag, "_mem_ena"}, ena_a[1], 1'b0);
    chk({tag, "_mem_wea"}, wea_a[1], 4'h0);
    chk({tag, "_mem_addra"}, addra_a[1], 32'h0);
    chk({tag, "_mem_dina"}, dina_a[1], 32'h0);
  endtask

  initial begin
    int acc;
    int bad;

    vecs[0] = '{32'h0000_1230, 1'b0, 32'h0, 128'h0,
                128'h0000052F_0000052E_0000052D_0000052C, 32'h0000_1230, 6};
    vecs[1] = '{32'h0000_2000, 1'b1, 32'h0000_4000,
                128'h00004444_00003333_00002222_00001111,
                128'h000008A3_000008A2_000008A1_000008A0, 32'h0000_2000, 10};
    vecs[2] = '{32'hFFFF_FFF0, 1'b1, 32'h0000_001F,
                128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA,
                128'h4000009F_4000009E_4000009D_4000009C, 32'hFFFF_FFF0, 10};
    vecs[3] = '{32'h0000_000F, 1'b0, 32'h0, 128'h0,
                128'h000000A3_000000A2_000000A1_000000A0, 32'h0000_0000, 6};

    // Reset state
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rsta_n = 1'b1;

    // Stall: nothing may move without a request
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (ena_a[1] || fill_valid_a[1]) bad++;
    end
    chk("stall_activity", bad, 0);
    $display("[TB] stall 100 cycles activity=%0d", bad);

    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // Back-to-back: req_valid held, second address presented after first accept
    wait_all_ready();
    @(negedge clk);
    blog.delete();
    req_addr = 32'h0000_5550; req_wb = 1'b0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    req_addr = 32'h0000_6660;
    while (cyc - acc < 14) begin
      @(negedge clk);
      if (cyc - acc == 6) begin
        chk("b2b_fill1_valid", fill_valid_a[1], 1'b1);
        chk("b2b_fill1_ready", req_ready_a[1], 1'b1);
        chk("b2b_fill1_line", fill_line_a[1], 128'h000015F7_000015F6_000015F5_000015F4);
      end
      if (cyc - acc == 7) begin
        chk("b2b_second_accepted", req_ready_a[1], 1'b0);
        req_valid = 1'b0;
      end
      if (cyc - acc == 13) begin
        chk("b2b_fill2_valid", fill_valid_a[1], 1'b1);
        chk("b2b_fill2_line", fill_line_a[1], 128'h00001A3B_00001A3A_00001A39_00001A38);
        chk("b2b_fill2_addr", fill_addr_a[1], 32'h0000_6660);
      end
    end
    chk("b2b_ena_cycles", blog.size(), 8);
    if (blog.size() >= 5) chk("b2b_second_first_beat", blog[4].cyc - acc, 8);
    $display("[TB] back-to-back ena_cycles=%0d", blog.size());

    // Reset during write beat 2
    wait_all_ready();
    @(negedge clk);
    req_addr = 32'h0000_3000; req_wb = 1'b1; wb_addr = 32'h0000_7000;
    wb_line = 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wb2_ena", ena_a[1], 1'b1);
    chk("rst_wb2_addr", addra_a[1], 32'h0000_1C02);
    clear_fills();
    rsta_n = 1'b0;
    #1;
    chk_reset_outputs("midwb_reset");
    repeat (2) @(negedge clk);
    rsta_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midwb_no_fill", fcnt[1], 0);
    chk("midwb_ready_after", req_ready_a[1], 1'b1);
    $display("[TB] reset mid-WB fills=%0d", fcnt[1]);
    run_vec(4, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
